mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply (and optional divide) unit for the MIPS pipeline, launched from Execute.
//  Produces 64-bit HI/LO results and drives multReady to the hazard unit.
//  The hazard unit stalls mfhi/mflo (mfReg=01/10) while !multReady || multStart.
//  hiLoOut feeds the mfhi/mflo result path.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk        in   1      pipeline clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  multStart  in   1      1-cycle launch pulse (mult/multu/div/divu in Execute)
//  multSigned in   1      1 = signed op (mult/div), 0 = unsigned (multu/divu); sampled with multStart
//  isDiv      in   1      1 = divide op; sampled with multStart; see CONFIGURATION
//  SrcAE      in   WIDTH  rs operand; sampled with multStart
//  SrcBE      in   WIDTH  rt operand; sampled with multStart
//  mfReg      in   2      01 = read HI, 10 = read LO, 00/11 = none
//  multReady  out  1      1 = no op in flight and HI/LO valid
//  hiLoOut    out  WIDTH  HI if mfReg=01, LO if mfReg=10, else 0 (combinational)
// BEHAVIOUR
//  Reset (async): HI=LO=0, state IDLE, multReady=1, counter=0, operand/accumulator regs=0.
//  FSM: IDLE --multStart--> RUN; RUN --count==WIDTH-1--> IDLE, HI/LO written on that edge.
//  Timing:
//   - multStart sampled at edge t0; multReady=0 from t0 onward.
//   - Exactly WIDTH RUN cycles; HI/LO updated and multReady=1 at edge t0+WIDTH.
//  multStart during RUN: current op aborted, new operands latched, counter cleared,
//   restart from scratch; HI/LO not written by the aborted op.
//  HI/LO hold previous committed values during RUN; partial results never visible on hiLoOut.
//  Multiply:
//   - Radix-2 shift-add on magnitudes, 2*WIDTH-bit accumulator.
//   - Signed: magnitude = two's-complement abs (0x80000000 -> 0x80000000 unsigned).
//     Product negated if operand signs differ.
//   - {HI,LO} = full 2*WIDTH-bit product, no overflow possible.
//  multSigned/isDiv/SrcAE/SrcBE ignored except in the multStart cycle.
//  mfReg has no effect on the FSM; stalling is the hazard unit's job.
//  Reset asserted mid-RUN: op discarded, all state returns to reset values immediately.
// CONFIGURATION
//  MULT_DIV_UNIT_DIV_EN defined:
//   - isDiv=1 runs restoring division on magnitudes, same WIDTH-cycle latency.
//   - LO = quotient, HI = remainder.
//   - Signed: quotient negated if signs differ; remainder takes dividend's sign.
//   - Divide by zero: LO = all ones, HI = dividend (SrcAE); same latency.
//   - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
//  MULT_DIV_UNIT_DIV_EN undefined:
//   - isDiv ignored; every op is a multiply; no divider logic synthesised.
// TESTING
//  1 Reset mid-RUN -> immediately multReady=1; mfReg=01 and 10 both give hiLoOut=0.
//  2 multu 0xFFFFFFFF*0xFFFFFFFF:
//    multReady=0 for 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
//  3 mult -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//    mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  4 Prior HI=0x11, then multu 2*3; mfReg=01 during RUN -> 0x11.
//    After completion: LO=6, HI=0.
//  5 multu 9*9 restarted at cycle 10 with 4*4 -> ready 32 cycles after restart.
//    LO=16 (81 never committed).
//  6 DIV_EN: div 7/-2 -> LO=0xFFFFFFFD, HI=1.
//    divu 5/0 -> LO=0xFFFFFFFF, HI=5.
//    Macro undefined: isDiv=1, 7,-2 signed -> LO=0xFFFFFFF2, HI=0xFFFFFFFF.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
// Define MULT_DIV_UNIT_DIV_EN to build the divider; otherwise every op is a multiply.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multStart,
    input  logic             multSigned,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [1:0]       mfReg,
    output logic             multReady,
    output logic [WIDTH-1:0] hiLoOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] mul_res;

    assign a_abs = (multSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign b_abs = (multSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

    // Shift-add step: low half of acc holds the remaining multiplier bits.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, b_mag} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign mul_res  = neg_q ? -mul_next : mul_next;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic               is_div;
    logic               div_zero;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
    assign div_sh    = {acc, 1'b0};
    assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, b_mag};
    assign div_next  = div_trial[WIDTH] ? div_sh[2*WIDTH-1:0]
                     : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    assign quo = div_next[WIDTH-1:0];
    assign rem = div_next[2*WIDTH-1:WIDTH];
`else
    logic unused_div;
    assign unused_div = isDiv;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            b_mag     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            multReady <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else if (multStart) begin
            // A new launch always wins, aborting any op in flight.
            state     <= RUN;
            count     <= '0;
            acc       <= {{WIDTH{1'b0}}, a_abs};
            b_mag     <= b_abs;
            neg_q     <= multSigned & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            neg_r     <= multSigned & SrcAE[WIDTH-1];
            multReady <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div    <= isDiv;
            div_zero  <= (SrcBE == '0);
`endif
        end else if (state == RUN) begin
            count <= count + 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
            acc   <= is_div ? div_next : mul_next;
`else
            acc   <= mul_next;
`endif
            if (count == LAST) begin
                state     <= IDLE;
                multReady <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
                if (is_div) begin
                    lo <= div_zero ? '1 : (neg_q ? -quo : quo);
                    hi <= neg_r ? -rem : rem;
                end else begin
                    hi <= mul_res[2*WIDTH-1:WIDTH];
                    lo <= mul_res[WIDTH-1:0];
                end
`else
                hi <= mul_res[2*WIDTH-1:WIDTH];
                lo <= mul_res[WIDTH-1:0];
`endif
            end
        end
    end

    always_comb begin
        hiLoOut = '0;
        if (mfReg == 2'b01) hiLoOut = hi;
        else if (mfReg == 2'b10) hiLoOut = lo;
    end
endmodule
